// File: rtl/updown_counter_mod.sv
// ---------------------------------------------------------------------------
// updown_counter_mod
//
// Parametrised up/down counter with a programmable step, a synchronous load,
// a configurable modulus (count range 0..MODULUS-1) and a choice between
// wrapping modulo MODULUS or clamping at the range ends.
//
// Every boundary crossing (wrap, or clamp attempt in saturate mode) raises
// wrap_o for one cycle and sets the matching sticky flag.
//
// Parameters
//   WIDTH     counter / step / load width in bits (>= 2)
//   MODULUS   number of count values, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0 = wrap modulo MODULUS, 1 = clamp at 0 / MODULUS-1
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   ce_i         count enable
//   up_i         1 = count up, 0 = count down
//   step_i       amount added/subtracted per enabled cycle
//   load_i       synchronous load, takes priority over ce_i
//   load_val_i   value to load (clamped to MODULUS-1)
//   clr_flags_i  clears the sticky ovf_o/unf_o flags
//   q_o          current count (registered)
//   wrap_o       one-cycle pulse: last update crossed a boundary
//   ovf_o        sticky: an up-count crossed MODULUS-1
//   unf_o        sticky: a down-count crossed 0
//   zero_o       q_o == 0
//   max_o        q_o == MODULUS-1
// ---------------------------------------------------------------------------
module updown_counter_mod #(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
   parameter bit              SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_i,
   input  logic             up_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             clr_flags_i,
   output logic [WIDTH-1:0] q_o,
   output logic             wrap_o,
   output logic             ovf_o,
   output logic             unf_o,
   output logic             zero_o,
   output logic             max_o
);

   // Modulus and top count, held one bit wider so MODULUS == 2**WIDTH fits.
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH:0]   sum_x;
   logic             ovf_evt;
   logic             unf_evt;

   always_comb begin
      q_d      = q_q;
      ovf_evt  = 1'b0;
      unf_evt  = 1'b0;

      // Steps larger than the range are treated as a full-range step.
      step_eff = (step_i > MAX_Q) ? MAX_Q : step_i;
      sum_x    = {1'b0, q_q} + {1'b0, step_eff};

      if (load_i) begin
         q_d = (load_val_i > MAX_Q) ? MAX_Q : load_val_i;
      end else if (ce_i) begin
         if (up_i) begin
            if (sum_x > MAX_X) begin
               ovf_evt = 1'b1;
               q_d     = SATURATE ? MAX_Q : WIDTH'(sum_x - MOD_X);
            end else begin
               q_d = sum_x[WIDTH-1:0];
            end
         end else begin
            if (q_q >= step_eff) begin
               q_d = q_q - step_eff;
            end else begin
               unf_evt = 1'b1;
               q_d     = SATURATE ? '0
                                  : WIDTH'({1'b0, q_q} + MOD_X - {1'b0, step_eff});
            end
         end
      end

      wrap_d = ovf_evt | unf_evt;
      // A new event on the same edge beats a clear request.
      ovf_d  = ovf_evt | (ovf_q & ~clr_flags_i);
      unf_d  = unf_evt | (unf_q & ~clr_flags_i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   assign q_o    = q_q;
   assign wrap_o = wrap_q;
   assign ovf_o  = ovf_q;
   assign unf_o  = unf_q;
   assign zero_o = (q_q == '0);
   assign max_o  = (q_q == MAX_Q);

endmodule
